// File: rtl/score_counter.sv
// score_counter
// -----------------------------------------------------------------------------
// Up/down score counter for the game score datapath. Increment and decrement
// requests come from the hit-detect and miss logic. The counter either
// saturates at 0 / MAX_COUNT or wraps modulo MAX_COUNT+1. It also keeps a
// running high-score register that the score display reads.
//
// Parameters
//   WIDTH        bit width of count, load_value and high_score
//   MAX_COUNT    terminal value, 1 .. 2^WIDTH-1
//   STEP         amount added or subtracted per event, 1 .. MAX_COUNT
//   SATURATE     1 = clamp at 0 / MAX_COUNT, 0 = wrap modulo MAX_COUNT+1
//   EDGE_DETECT  1 = count on rising edges of the requests,
//                0 = count every cycle a request is high
//
// Ports
//   clk         system clock, all logic on posedge
//   reset       synchronous active-high reset, clears everything
//   clear       synchronous count clear, high_score retained
//   load        synchronous load of load_value (clamped to MAX_COUNT)
//   load_value  value loaded when load=1
//   increment   up request
//   decrement   down request
//   count       current score (registered)
//   high_score  maximum count reached since reset (registered)
//   at_max      count == MAX_COUNT
//   at_zero     count == 0
//   overflow    one-cycle pulse, an up event went past MAX_COUNT
//   underflow   one-cycle pulse, a down event went below 0
//   new_high    one-cycle pulse, high_score was updated
//
// Priority per cycle: reset > clear > load > increment/decrement.
// -----------------------------------------------------------------------------
module score_counter #(
    parameter int WIDTH       = 8,
    parameter int MAX_COUNT   = 255,
    parameter int STEP        = 1,
    parameter bit SATURATE    = 1'b1,
    parameter bit EDGE_DETECT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             increment,
    input  logic             decrement,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] high_score,
    output logic             at_max,
    output logic             at_zero,
    output logic             overflow,
    output logic             underflow,
    output logic             new_high
);

    // Out-of-range parameters are flagged at elaboration.
    if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
        $error("score_counter: WIDTH=%0d out of range", WIDTH);
    end
    if (MAX_COUNT < 1 || longint'(MAX_COUNT) > (longint'(1) << WIDTH) - 1) begin : g_bad_max
        $error("score_counter: MAX_COUNT=%0d out of range", MAX_COUNT);
    end
    if (STEP < 1 || STEP > MAX_COUNT) begin : g_bad_step
        $error("score_counter: STEP=%0d out of range", STEP);
    end

    // Arithmetic is done one bit wider so count+STEP and MAX_COUNT+1 never
    // lose their carry.
    localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MAX_COUNT + 1);
    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_COUNT);

    logic             inc_q;
    logic             dec_q;
    logic             up_evt;
    logic             dn_evt;
    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   up_wrap;
    logic [WIDTH:0]   dn_sub;
    logic [WIDTH:0]   dn_wrap;
    logic             up_ovf;
    logic             dn_unf;
    logic [WIDTH-1:0] load_clamped;

    always_comb begin
        if (EDGE_DETECT) begin
            up_evt = increment & ~inc_q;
            dn_evt = decrement & ~dec_q;
        end else begin
            up_evt = increment;
            dn_evt = decrement;
        end
    end

    assign count_ext    = {1'b0, count};
    assign up_sum       = count_ext + STEP_EXT;
    assign up_ovf       = (up_sum > MAX_EXT);
    assign up_wrap      = up_sum - MOD_EXT;
    assign dn_unf       = (count_ext < STEP_EXT);
    assign dn_sub       = count_ext - STEP_EXT;
    // Only used when count < STEP, so the result is below MAX_COUNT+1.
    assign dn_wrap      = count_ext + MOD_EXT - STEP_EXT;
    assign load_clamped = (load_value > MAX_W) ? MAX_W : load_value;

    assign at_max  = (count == MAX_W);
    assign at_zero = (count == '0);

    always_ff @(posedge clk) begin
        // Request history is tracked unconditionally, so a request held high
        // across reset, clear or load does not look like a fresh edge later.
        inc_q <= increment;
        dec_q <= decrement;

        if (reset) begin
            count      <= '0;
            high_score <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            new_high   <= 1'b0;
        end else begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            new_high  <= 1'b0;

            // high_score follows the registered count, one cycle behind it.
            if (count > high_score) begin
                high_score <= count;
                new_high   <= 1'b1;
            end

            if (clear) begin
                count <= '0;
            end else if (load) begin
                count <= load_clamped;
            end else if (up_evt && !dn_evt) begin
                if (!up_ovf) begin
                    count <= up_sum[WIDTH-1:0];
                end else begin
                    overflow <= 1'b1;
                    count    <= SATURATE ? MAX_W : up_wrap[WIDTH-1:0];
                end
            end else if (dn_evt && !up_evt) begin
                if (!dn_unf) begin
                    count <= dn_sub[WIDTH-1:0];
                end else begin
                    underflow <= 1'b1;
                    count     <= SATURATE ? '0 : dn_wrap[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter
// -----------------------------------------------------------------------------
// Bench for score_counter. Four instances with different parameter sets share
// one stimulus stream:
//   dut 0: defaults (WIDTH 8, MAX 255, STEP 1, saturate, edge detect)
//   dut 1: WIDTH 8, MAX 9, STEP 3, wrap, edge detect
//   dut 2: WIDTH 8, MAX 255, STEP 1, saturate, level counting
//   dut 3: WIDTH 9, MAX 300, STEP 7, saturate, edge detect
// A behavioural model tracks every instance from the rules in plain integer
// arithmetic; directed scenarios also check hand-derived constants.
// -----------------------------------------------------------------------------
module tb_score_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       load;
    logic [8:0] load_value;
    logic       increment;
    logic       decrement;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ---------------- DUT instances ----------------
    logic [7:0] c0, h0, c1, h1, c2, h2;
    logic [8:0] c3, h3;
    logic       am[4], az[4], ov[4], un[4], nh[4];
    logic [8:0] o_count[4];
    logic [8:0] o_hs[4];

    score_counter u_d0 (
        .clk(clk), .reset(reset), .clear(clear), .load(load),
        .load_value(load_value[7:0]), .increment(increment), .decrement(decrement),
        .count(c0), .high_score(h0), .at_max(am[0]), .at_zero(az[0]),
        .overflow(ov[0]), .underflow(un[0]), .new_high(nh[0])
    );

    score_counter #(.WIDTH(8), .MAX_COUNT(9), .STEP(3), .SATURATE(1'b0), .EDGE_DETECT(1'b1)) u_d1 (
        .clk(clk), .reset(reset), .clear(clear), .load(load),
        .load_value(load_value[7:0]), .increment(increment), .decrement(decrement),
        .count(c1), .high_score(h1), .at_max(am[1]), .at_zero(az[1]),
        .overflow(ov[1]), .underflow(un[1]), .new_high(nh[1])
    );

    score_counter #(.WIDTH(8), .MAX_COUNT(255), .STEP(1), .SATURATE(1'b1), .EDGE_DETECT(1'b0)) u_d2 (
        .clk(clk), .reset(reset), .clear(clear), .load(load),
        .load_value(load_value[7:0]), .increment(increment), .decrement(decrement),
        .count(c2), .high_score(h2), .at_max(am[2]), .at_zero(az[2]),
        .overflow(ov[2]), .underflow(un[2]), .new_high(nh[2])
    );

    score_counter #(.WIDTH(9), .MAX_COUNT(300), .STEP(7), .SATURATE(1'b1), .EDGE_DETECT(1'b1)) u_d3 (
        .clk(clk), .reset(reset), .clear(clear), .load(load),
        .load_value(load_value), .increment(increment), .decrement(decrement),
        .count(c3), .high_score(h3), .at_max(am[3]), .at_zero(az[3]),
        .overflow(ov[3]), .underflow(un[3]), .new_high(nh[3])
    );

    always_comb begin
        o_count[0] = {1'b0, c0}; o_hs[0] = {1'b0, h0};
        o_count[1] = {1'b0, c1}; o_hs[1] = {1'b0, h1};
        o_count[2] = {1'b0, c2}; o_hs[2] = {1'b0, h2};
        o_count[3] = c3;         o_hs[3] = h3;
    end

    // ---------------- reference model ----------------
    int p_width[4] = '{8, 8, 8, 9};
    int p_max[4]   = '{255, 9, 255, 300};
    int p_step[4]  = '{1, 3, 1, 7};
    bit p_sat[4]   = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit p_edge[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};

    int m_cnt[4];
    int m_hs[4];
    bit m_ov[4], m_un[4], m_nh[4];
    bit m_prev_inc = 1'b0;
    bit m_prev_dec = 1'b0;

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            bit up, dn;
            int lv, modulus;
            up      = p_edge[i] ? (increment && !m_prev_inc) : increment;
            dn      = p_edge[i] ? (decrement && !m_prev_dec) : decrement;
            lv      = int'(load_value) % (1 << p_width[i]);
            modulus = p_max[i] + 1;
            m_ov[i] = 1'b0;
            m_un[i] = 1'b0;
            m_nh[i] = 1'b0;
            if (reset) begin
                m_cnt[i] = 0;
                m_hs[i]  = 0;
            end else begin
                if (m_cnt[i] > m_hs[i]) begin
                    m_hs[i] = m_cnt[i];
                    m_nh[i] = 1'b1;
                end
                if (clear) begin
                    m_cnt[i] = 0;
                end else if (load) begin
                    m_cnt[i] = (lv < p_max[i]) ? lv : p_max[i];
                end else if (up && !dn) begin
                    if (m_cnt[i] + p_step[i] > p_max[i]) begin
                        m_ov[i]  = 1'b1;
                        m_cnt[i] = p_sat[i] ? p_max[i] : (m_cnt[i] + p_step[i]) % modulus;
                    end else begin
                        m_cnt[i] = m_cnt[i] + p_step[i];
                    end
                end else if (dn && !up) begin
                    if (m_cnt[i] - p_step[i] < 0) begin
                        m_un[i]  = 1'b1;
                        m_cnt[i] = p_sat[i] ? 0 : ((m_cnt[i] - p_step[i]) % modulus + modulus) % modulus;
                    end else begin
                        m_cnt[i] = m_cnt[i] - p_step[i];
                    end
                end
            end
        end
        m_prev_inc = increment;
        m_prev_dec = decrement;
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit r, input bit c, input bit l, input int lv,
                         input bit inc, input bit dec);
        reset      = r;
        clear      = c;
        load       = l;
        load_value = 9'(lv);
        increment  = inc;
        decrement  = dec;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_count[i] !== 9'd0 || o_hs[i] !== 9'd0 || az[i] !== 1'b1 || am[i] !== 1'b0 ||
                ov[i] !== 1'b0 || un[i] !== 1'b0 || nh[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: count=%0d hs=%0d az=%b am=%b ov=%b un=%b nh=%b, required 0 0 1 0 0 0 0",
                         i, o_count[i], o_hs[i], az[i], am[i], ov[i], un[i], nh[i]);
            end
        end
    endtask

    task automatic test_defaults();
        int nh_seen = 0;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            cycle(0, 0, 0, 0, 1, 0);
            if (nh[0]) nh_seen++;
            checks++;
            if (c0 !== 8'(k)) begin
                errors++;
                $display("FAIL defaults_count event %0d: got %0d required %0d", k, c0, k);
            end
            cycle(0, 0, 0, 0, 0, 0);
            if (nh[0]) nh_seen++;
        end
        cycle(0, 0, 0, 0, 0, 0);
        if (nh[0]) nh_seen++;
        checks++;
        if (h0 !== 8'd3) begin
            errors++;
            $display("FAIL defaults_high_score: got %0d required 3", h0);
        end
        checks++;
        if (nh_seen != 3) begin
            errors++;
            $display("FAIL defaults_new_high_pulses: got %0d required 3", nh_seen);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        cycle(0, 0, 1, 254, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 0, 1, 0);
            checks++;
            if (c0 !== 8'd255 || ov[0] !== (k > 0) || am[0] !== 1'b1) begin
                errors++;
                $display("FAIL saturate_up event %0d: count=%0d ov=%b at_max=%b, required 255 %b 1",
                         k + 1, c0, ov[0], am[0], (k > 0));
            end
            cycle(0, 0, 0, 0, 0, 0);
        end
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        checks++;
        if (c0 !== 8'd0 || un[0] !== 1'b1 || az[0] !== 1'b1) begin
            errors++;
            $display("FAIL saturate_down: count=%0d un=%b az=%b, required 0 1 1", c0, un[0], az[0]);
        end
        cycle(0, 0, 0, 0, 0, 0);
        checks++;
        if (un[0] !== 1'b0) begin
            errors++;
            $display("FAIL saturate_un_pulse_width: un=%b required 0", un[0]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        cycle(0, 0, 1, 8, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        checks++;
        if (c1 !== 8'd1 || ov[1] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_up: count=%0d ov=%b, required 1 1", c1, ov[1]);
        end
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        checks++;
        if (c1 !== 8'd8 || un[1] !== 1'b1 || ov[1] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_down: count=%0d un=%b ov=%b, required 8 1 0", c1, un[1], ov[1]);
        end
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_edge_detect();
        do_reset();
        for (int k = 0; k < 10; k++) cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0);
        checks++;
        if (c0 !== 8'd1) begin
            errors++;
            $display("FAIL edge_held_high: count=%0d required 1", c0);
        end
        checks++;
        if (c2 !== 8'd10) begin
            errors++;
            $display("FAIL level_held_high: count=%0d required 10", c2);
        end
        cycle(1, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 1, 0);
        checks++;
        if (c0 !== 8'd0 || c3 !== 9'd0) begin
            errors++;
            $display("FAIL edge_through_reset: count0=%0d count3=%0d required 0 0", c0, c3);
        end
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_priority();
        do_reset();
        cycle(0, 0, 1, 5, 0, 0);
        cycle(0, 0, 0, 0, 1, 1);
        checks++;
        if (c0 !== 8'd5 || ov[0] !== 1'b0 || un[0] !== 1'b0) begin
            errors++;
            $display("FAIL simultaneous: count=%0d ov=%b un=%b, required 5 0 0", c0, ov[0], un[0]);
        end
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 300, 1, 0);
        checks++;
        if (c3 !== 9'd300 || ov[3] !== 1'b0 || am[3] !== 1'b1) begin
            errors++;
            $display("FAIL load_with_inc: count=%0d ov=%b am=%b, required 300 0 1", c3, ov[3], am[3]);
        end
        cycle(0, 0, 1, 511, 0, 0);
        checks++;
        if (c3 !== 9'd300 || c0 !== 8'd255) begin
            errors++;
            $display("FAIL load_clamp: count3=%0d count0=%0d, required 300 255", c3, c0);
        end
        cycle(0, 1, 0, 0, 1, 0);
        checks++;
        if (c0 !== 8'd0 || c3 !== 9'd0 || ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL clear_with_inc: count0=%0d count3=%0d ov=%b, required 0 0 0", c0, c3, ov[0]);
        end
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_clear_vs_reset();
        int nh_seen = 0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 0, 0, 1, 0);
            cycle(0, 0, 0, 0, 0, 0);
        end
        cycle(0, 1, 0, 0, 0, 0);
        checks++;
        if (c0 !== 8'd0 || h0 !== 8'd5) begin
            errors++;
            $display("FAIL clear_keeps_high: count=%0d hs=%0d, required 0 5", c0, h0);
        end
        for (int k = 0; k < 2; k++) begin
            cycle(0, 0, 0, 0, 1, 0);
            if (nh[0]) nh_seen++;
            cycle(0, 0, 0, 0, 0, 0);
            if (nh[0]) nh_seen++;
        end
        checks++;
        if (c0 !== 8'd2 || h0 !== 8'd5 || nh_seen != 0) begin
            errors++;
            $display("FAIL below_high: count=%0d hs=%0d new_high_pulses=%0d, required 2 5 0", c0, h0, nh_seen);
        end
        cycle(1, 0, 0, 0, 1, 0);
        checks++;
        if (c0 !== 8'd0 || h0 !== 8'd0 || ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_increment: count=%0d hs=%0d ov=%b, required 0 0 0", c0, h0, ov[0]);
        end
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit r, c, l, inc, dec;
            int lv;
            r   = ($urandom_range(0, 199) == 0);
            c   = ($urandom_range(0, 59) == 0);
            l   = ($urandom_range(0, 39) == 0);
            lv  = $urandom_range(0, 511);
            inc = ($urandom_range(0, 2) != 0);
            dec = ($urandom_range(0, 3) == 0);
            cycle(r, c, l, lv, inc, dec);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (o_count[i] !== 9'(m_cnt[i]) || o_hs[i] !== 9'(m_hs[i]) ||
                    ov[i] !== m_ov[i] || un[i] !== m_un[i] || nh[i] !== m_nh[i] ||
                    am[i] !== (m_cnt[i] == p_max[i]) || az[i] !== (m_cnt[i] == 0)) begin
                    errors++;
                    $display("FAIL random dut%0d cycle %0d: count=%0d hs=%0d ov=%b un=%b nh=%b am=%b az=%b, required %0d %0d %b %b %b %b %b",
                             i, n, o_count[i], o_hs[i], ov[i], un[i], nh[i], am[i], az[i],
                             m_cnt[i], m_hs[i], m_ov[i], m_un[i], m_nh[i],
                             (m_cnt[i] == p_max[i]), (m_cnt[i] == 0));
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        clear      = 1'b0;
        load       = 1'b0;
        load_value = '0;
        increment  = 1'b0;
        decrement  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_hs[i]  = 0;
        end
        test_reset();
        test_defaults();
        test_saturate();
        test_wrap();
        test_edge_detect();
        test_priority();
        test_clear_vs_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
